// File: rtl/pin_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pin_cfg_sequencer_if
// Brief    : Requester handshakes and pad-block configuration port of the
//            pin configuration sequencer, plus its status shadows.
// Revision : 1.0  initial release
// ============================================================================
interface pin_cfg_sequencer_if #(
    parameter int IO_PINS = 16
);
    logic               host_req;
    logic               host_addr;
    logic [IO_PINS-1:0] host_wdata;
    logic               host_ack;
    logic               core_req;
    logic [IO_PINS-1:0] core_wdata;
    logic               core_ack;
    logic               core_err;
    logic               cfg_we;
    logic               cfg_addr;
    logic [IO_PINS-1:0] cfg_wdata;
    logic               programming;
    logic [IO_PINS-1:0] cur_dir;
    logic               busy;

    // Requester / observer side
    modport master (
        output host_req, host_addr, host_wdata, core_req, core_wdata,
        input  host_ack, core_ack, core_err, cfg_we, cfg_addr, cfg_wdata,
               programming, cur_dir, busy
    );

    // Sequencer side
    modport slave (
        input  host_req, host_addr, host_wdata, core_req, core_wdata,
        output host_ack, core_ack, core_err, cfg_we, cfg_addr, cfg_wdata,
               programming, cur_dir, busy
    );
endinterface
`default_nettype wire

// File: rtl/pin_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pin_cfg_sequencer
// Brief    : Arbitrates host/core configuration writes to the pad block,
//            shadows the programming flag and pin directions, and sequences
//            direction changes so outputs are released before new outputs
//            are enabled after a turnaround delay.
// Revision : 1.0  initial release
// ============================================================================
module pin_cfg_sequencer #(
    parameter int IO_PINS     = 16,
    parameter int TURN_CYCLES = 4
) (
    input  wire logic            wb_clk_i,
    input  wire logic            wb_rst_i,
    pin_cfg_sequencer_if.slave   bus
);
    localparam int             c_CNT_W = $clog2(TURN_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TURN = c_CNT_W'(TURN_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        REL   = 3'd2,
        WAIT  = 3'd3,
        APPLY = 3'd4
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,         w_cnt_nxt;
    logic               r_prefer_core, w_prefer_core_nxt;
    logic               r_gnt_core,    w_gnt_core_nxt;
    logic [IO_PINS-1:0] r_new_dir,     w_new_dir_nxt;
    logic               r_host_ack,    w_host_ack_nxt;
    logic               r_core_ack,    w_core_ack_nxt;
    logic               r_core_err,    w_core_err_nxt;
    logic               r_cfg_we,      w_cfg_we_nxt;
    logic               r_cfg_addr,    w_cfg_addr_nxt;
    logic [IO_PINS-1:0] r_cfg_wdata,   w_cfg_wdata_nxt;
    logic               r_programming, w_programming_nxt;
    logic [IO_PINS-1:0] r_cur_dir,     w_cur_dir_nxt;
    logic               r_busy,        w_busy_nxt;

    logic               w_host_win;
    logic               w_core_win;
    logic [IO_PINS-1:0] w_req_dir;
    logic [IO_PINS-1:0] w_new_bits;

    // State, shadows and all outputs are registered together
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_prefer_core <= 1'b0;
            r_gnt_core    <= 1'b0;
            r_new_dir     <= '0;
            r_host_ack    <= 1'b0;
            r_core_ack    <= 1'b0;
            r_core_err    <= 1'b0;
            r_cfg_we      <= 1'b0;
            r_cfg_addr    <= 1'b0;
            r_cfg_wdata   <= '0;
            r_programming <= 1'b0;
            r_cur_dir     <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_prefer_core <= w_prefer_core_nxt;
            r_gnt_core    <= w_gnt_core_nxt;
            r_new_dir     <= w_new_dir_nxt;
            r_host_ack    <= w_host_ack_nxt;
            r_core_ack    <= w_core_ack_nxt;
            r_core_err    <= w_core_err_nxt;
            r_cfg_we      <= w_cfg_we_nxt;
            r_cfg_addr    <= w_cfg_addr_nxt;
            r_cfg_wdata   <= w_cfg_wdata_nxt;
            r_programming <= w_programming_nxt;
            r_cur_dir     <= w_cur_dir_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Arbitration, next state and next values of every registered output
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_prefer_core_nxt = r_prefer_core;
        w_gnt_core_nxt    = r_gnt_core;
        w_new_dir_nxt     = r_new_dir;
        w_host_ack_nxt    = 1'b0;
        w_core_ack_nxt    = 1'b0;
        w_core_err_nxt    = 1'b0;
        w_cfg_we_nxt      = 1'b0;
        w_cfg_addr_nxt    = r_cfg_addr;
        w_cfg_wdata_nxt   = r_cfg_wdata;
        w_programming_nxt = r_programming;
        w_cur_dir_nxt     = r_cur_dir;

        // Host wins unless the core also requests and it is the core's turn
        w_host_win = bus.host_req & (~bus.core_req | ~r_prefer_core);
        w_core_win = bus.core_req & ~w_host_win;
        w_req_dir  = w_host_win ? bus.host_wdata : bus.core_wdata;
        w_new_bits = w_req_dir & ~r_cur_dir;

        case (r_state)
            IDLE: begin
                if (w_host_win || w_core_win) begin
                    w_gnt_core_nxt    = w_core_win;
                    w_new_dir_nxt     = w_req_dir;
                    w_prefer_core_nxt = w_host_win;
                    if (w_core_win && r_programming) begin
                        // Core writes are refused while programming
                        w_state_nxt    = WRITE;
                        w_core_ack_nxt = 1'b1;
                        w_core_err_nxt = 1'b1;
                    end else if (w_host_win && !bus.host_addr) begin
                        w_state_nxt       = WRITE;
                        w_cfg_we_nxt      = 1'b1;
                        w_cfg_addr_nxt    = 1'b0;
                        w_cfg_wdata_nxt   = bus.host_wdata;
                        w_programming_nxt = bus.host_wdata[0];
                        w_host_ack_nxt    = 1'b1;
                    end else if (w_new_bits == '0) begin
                        // Only releases or no change: safe in one write
                        w_state_nxt     = WRITE;
                        w_cfg_we_nxt    = 1'b1;
                        w_cfg_addr_nxt  = 1'b1;
                        w_cfg_wdata_nxt = w_req_dir;
                        w_cur_dir_nxt   = w_req_dir;
                        w_host_ack_nxt  = w_host_win;
                        w_core_ack_nxt  = w_core_win;
                    end else begin
                        // Release outputs that go away before enabling new ones
                        w_state_nxt     = REL;
                        w_cfg_we_nxt    = 1'b1;
                        w_cfg_addr_nxt  = 1'b1;
                        w_cfg_wdata_nxt = r_cur_dir & w_req_dir;
                        w_cur_dir_nxt   = r_cur_dir & w_req_dir;
                    end
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            REL: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = c_TURN;
            end
            WAIT: begin
                if (r_cnt == c_ONE) begin
                    w_state_nxt     = APPLY;
                    w_cfg_we_nxt    = 1'b1;
                    w_cfg_addr_nxt  = 1'b1;
                    w_cfg_wdata_nxt = r_new_dir;
                    w_cur_dir_nxt   = r_new_dir;
                    w_host_ack_nxt  = ~r_gnt_core;
                    w_core_ack_nxt  = r_gnt_core;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            APPLY: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.host_ack    = r_host_ack;
    assign bus.core_ack    = r_core_ack;
    assign bus.core_err    = r_core_err;
    assign bus.cfg_we      = r_cfg_we;
    assign bus.cfg_addr    = r_cfg_addr;
    assign bus.cfg_wdata   = r_cfg_wdata;
    assign bus.programming = r_programming;
    assign bus.cur_dir     = r_cur_dir;
    assign bus.busy        = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_pin_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_cfg_sequencer
// Brief    : Directed self-checking bench for pin_cfg_sequencer
//            (IO_PINS=16, TURN_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_pin_cfg_sequencer;
    localparam int c_PINS = 16;
    localparam int c_TURN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pin_cfg_sequencer_if #(.IO_PINS(c_PINS)) bus ();

    pin_cfg_sequencer #(
        .IO_PINS     (c_PINS),
        .TURN_CYCLES (c_TURN)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; observe/drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host write of any kind, waits for ack, returns to IDLE
    task automatic host_wr(input logic addr, input logic [15:0] data);
        int n;
        bus.host_addr  = addr;
        bus.host_wdata = data;
        bus.host_req   = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.host_ack && n < 40);
        if (!bus.host_ack) check("host_wr_timeout", 32'd0, 32'd1);
        bus.host_req = 1'b0;
        tick();
    endtask

    initial begin
        int  cnt;
        int  g;
        int  overlap;
        int  dbl;
        logic h_rearm, c_rearm, prev_h, prev_c;
        logic [7:0] order [3];

        bus.host_req   = 1'b0;
        bus.host_addr  = 1'b0;
        bus.host_wdata = '0;
        bus.core_req   = 1'b0;
        bus.core_wdata = '0;

        // ---------------- reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_cfg_we", 32'(bus.cfg_we), 32'd0);
        check("rst_prog",   32'(bus.programming), 32'd0);
        check("rst_curdir", 32'(bus.cur_dir), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_acks",   32'({bus.host_ack, bus.core_ack, bus.core_err}), 32'd0);

        // ---------------- host sets programming flag
        bus.host_addr = 1'b0; bus.host_wdata = 16'h0001; bus.host_req = 1'b1;
        tick();
        check("prog_we",    32'(bus.cfg_we), 32'd1);
        check("prog_addr",  32'(bus.cfg_addr), 32'd0);
        check("prog_data0", 32'(bus.cfg_wdata[0]), 32'd1);
        check("prog_ack",   32'(bus.host_ack), 32'd1);
        check("prog_flag",  32'(bus.programming), 32'd1);
        check("prog_busy",  32'(bus.busy), 32'd1);
        bus.host_req = 1'b0;
        tick();
        check("prog_idle",  32'({bus.cfg_we, bus.host_ack, bus.busy}), 32'd0);

        // ---------------- release-only core write
        host_wr(1'b1, 16'h00FF);
        check("setup_dir",  32'(bus.cur_dir), 32'h00FF);
        host_wr(1'b0, 16'h0000);
        check("setup_prog", 32'(bus.programming), 32'd0);
        bus.core_wdata = 16'h000F; bus.core_req = 1'b1;
        tick();
        check("rel_we",     32'({bus.cfg_we, bus.cfg_addr}), 32'h3);
        check("rel_data",   32'(bus.cfg_wdata), 32'h000F);
        check("rel_ack",    32'({bus.core_ack, bus.core_err}), 32'h2);
        check("rel_curdir", 32'(bus.cur_dir), 32'h000F);
        bus.core_req = 1'b0;
        tick();
        check("rel_done",   32'({bus.cfg_we, bus.core_ack, bus.busy}), 32'd0);

        // ---------------- sequenced host direction change
        host_wr(1'b1, 16'h00FF);
        bus.host_addr = 1'b1; bus.host_wdata = 16'h0F0F; bus.host_req = 1'b1;
        tick();
        check("seq_rel_we",   32'({bus.cfg_we, bus.cfg_addr, bus.host_ack}), 32'h6);
        check("seq_rel_data", 32'(bus.cfg_wdata), 32'h000F);
        check("seq_rel_dir",  32'(bus.cur_dir), 32'h000F);
        cnt = 0;
        for (int i = 0; i < c_TURN; i++) begin
            tick();
            if (!bus.cfg_we && !bus.host_ack && bus.busy) cnt++;
        end
        check("seq_wait_cycles", 32'(cnt), 32'd4);
        tick();
        check("seq_apply_we",   32'({bus.cfg_we, bus.cfg_addr, bus.host_ack}), 32'h7);
        check("seq_apply_data", 32'(bus.cfg_wdata), 32'h0F0F);
        check("seq_apply_dir",  32'(bus.cur_dir), 32'h0F0F);
        bus.host_req = 1'b0;
        tick();
        check("seq_hold_data",  32'({bus.cfg_we, bus.cfg_wdata}), 32'h0F0F);

        // ---------------- round-robin from reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.host_addr = 1'b1; bus.host_wdata = 16'h0000; bus.core_wdata = 16'h0000;
        bus.host_req = 1'b1; bus.core_req = 1'b1;
        g = 0; overlap = 0; dbl = 0;
        h_rearm = 1'b0; c_rearm = 1'b0; prev_h = 1'b0; prev_c = 1'b0;
        for (int i = 0; i < 30 && g < 3; i++) begin
            tick();
            if (h_rearm) begin bus.host_req = 1'b1; h_rearm = 1'b0; end
            if (c_rearm) begin bus.core_req = 1'b1; c_rearm = 1'b0; end
            if (bus.host_ack && bus.core_ack) overlap++;
            if ((bus.host_ack && prev_h) || (bus.core_ack && prev_c)) dbl++;
            prev_h = bus.host_ack; prev_c = bus.core_ack;
            if (bus.host_ack) begin order[g] = "H"; g++; bus.host_req = 1'b0; h_rearm = 1'b1; end
            else if (bus.core_ack) begin order[g] = "C"; g++; bus.core_req = 1'b0; c_rearm = 1'b1; end
        end
        bus.host_req = 1'b0; bus.core_req = 1'b0;
        check("rr_grants", 32'(g), 32'd3);
        if (g == 3) begin
            check("rr_first",  32'(order[0]), 32'(8'h48));
            check("rr_second", 32'(order[1]), 32'(8'h43));
            check("rr_third",  32'(order[2]), 32'(8'h48));
        end
        check("rr_overlap", 32'(overlap), 32'd0);
        check("rr_double",  32'(dbl), 32'd0);
        tick(); tick();

        // ---------------- core rejected while programming
        host_wr(1'b0, 16'h0001);
        bus.core_wdata = 16'hFFFF; bus.core_req = 1'b1;
        tick();
        check("rej_ack",    32'({bus.core_ack, bus.core_err}), 32'h3);
        check("rej_no_we",  32'(bus.cfg_we), 32'd0);
        check("rej_curdir", 32'(bus.cur_dir), 32'h0000);
        bus.core_req = 1'b0;
        tick();
        check("rej_after",  32'({bus.core_ack, bus.cfg_we, bus.programming}), 32'h1);

        // ---------------- reset during WAIT
        host_wr(1'b0, 16'h0000);
        bus.core_wdata = 16'h00F0; bus.core_req = 1'b1;
        tick();
        check("abort_rel",  32'({bus.cfg_we, bus.cfg_wdata}), 32'h10000);
        tick();
        rst = 1'b1; bus.core_req = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_outs", 32'({bus.cfg_we, bus.cfg_addr, bus.cfg_wdata, bus.host_ack,
                                 bus.core_ack, bus.core_err, bus.busy, bus.programming}), 32'd0);
        check("abort_dir",  32'(bus.cur_dir), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cfg_we || bus.core_ack || bus.host_ack) cnt++;
        end
        check("abort_quiet", 32'(cnt), 32'd0);
        bus.core_wdata = 16'h0003; bus.core_req = 1'b1;
        tick();
        check("post_rel",   32'({bus.cfg_we, bus.cfg_wdata}), 32'h10000);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.core_ack && cnt < 20);
        check("post_lat",   32'(cnt), 32'd5);
        check("post_apply", 32'({bus.cfg_we, bus.core_err, bus.cfg_wdata}), 32'h20003);
        check("post_dir",   32'(bus.cur_dir), 32'h0003);
        bus.core_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
